// File: rtl/lsu_mem_if.sv
// lsu_mem_if: load/store unit between the memory stage and a variable-latency data bus.
// Converts one stage access into a single-outstanding request/ready transaction,
// positions store data under byte strobes, aligns and extends load data, and stalls
// the stage while the bus is busy. Misaligned/illegal accesses and bus timeouts are
// reported as one-cycle pulses.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   memAdrs, memDataWD    byte address and store data from the memory stage
//   dmem_SEL              funct3 access mode
//   dmem_WE, dmem_RE      store / load request (both high means store)
//   flush_M               kills a request presented while idle
//   memDataRD             aligned, extended load result (held until next completion)
//   stall_req             holds the memory stage and upstream
//   misalign, bus_err     fault and timeout pulses
//   mem_*                 data bus request channel and response
module lsu_mem_if #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] memAdrs,
    input  logic [31:0] memDataWD,
    input  logic [2:0]  dmem_SEL,
    input  logic        dmem_WE,
    input  logic        dmem_RE,
    input  logic        flush_M,
    output logic [31:0] memDataRD,
    output logic        stall_req,
    output logic        misalign,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           state_q, state_d;
    logic [29:0]      addr_q, addr_d;
    logic [1:0]       lane_q, lane_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic             we_q, we_d;
    logic [2:0]       mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rd_q, rd_d;
    logic             err_q, err_d;

    logic        access, fault, idle;
    logic [3:0]  st_strb;
    logic [31:0] st_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    assign access = (dmem_WE | dmem_RE) & ~flush_M;
    assign idle   = (state_q == StIdle);

    // Misalignment and illegal-mode detection share one fault output.
    always_comb begin
        fault = 1'b0;
        case (dmem_SEL)
            3'b000:          fault = 1'b0;
            3'b001:          fault = memAdrs[0];
            3'b010:          fault = (memAdrs[1:0] != 2'b00);
            3'b100:          fault = dmem_WE;
            3'b101:          fault = dmem_WE | memAdrs[0];
            default:         fault = 1'b1;
        endcase
    end

    // Store lane placement; replicated data lets the strobes pick the lane.
    always_comb begin
        st_strb = 4'b1111;
        st_data = memDataWD;
        case (dmem_SEL[1:0])
            2'b00: begin
                st_strb = 4'b0001 << memAdrs[1:0];
                st_data = {4{memDataWD[7:0]}};
            end
            2'b01: begin
                st_strb = memAdrs[1] ? 4'b1100 : 4'b0011;
                st_data = {2{memDataWD[15:0]}};
            end
            default: begin
                st_strb = 4'b1111;
                st_data = memDataWD;
            end
        endcase
    end

    // Load extraction uses the registered lane and mode, not the live inputs.
    always_comb begin
        case (lane_q)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (mode_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        lane_d  = lane_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        we_d    = we_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (access && !fault) begin
                    addr_d  = memAdrs[31:2];
                    lane_d  = memAdrs[1:0];
                    we_d    = dmem_WE;
                    mode_d  = dmem_SEL;
                    wdata_d = dmem_WE ? st_data : 32'h0;
                    wstrb_d = dmem_WE ? st_strb : 4'h0;
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (mem_ready) begin
                    rd_d    = we_q ? 32'h0 : ld_ext;
                    state_d = StDone;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rd_d    = 32'h0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            lane_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            we_q    <= 1'b0;
            mode_q  <= '0;
            cnt_q   <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            lane_q  <= lane_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            we_q    <= we_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    assign mem_req   = (state_q == StBusy);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;
    assign bus_err   = err_q;
    assign stall_req = ~reset & ((idle & access & ~fault) | mem_req);
    assign misalign  = ~reset & idle & access & fault;
    assign memDataRD = (idle & access & fault) ? 32'h0 : rd_q;

endmodule

// File: tb/tb_lsu_mem_if.sv
module tb_lsu_mem_if;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] memAdrs, memDataWD, memDataRD, mem_wdata, mem_rdata;
    logic [2:0]  dmem_SEL;
    logic        dmem_WE, dmem_RE, flush_M;
    logic        stall_req, misalign, bus_err, mem_req, mem_we, mem_ready;
    logic [29:0] mem_addr;
    logic [3:0]  mem_wstrb;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lsu_mem_if #(.TIMEOUT(64), .CNT_W(7)) dut (
        .clk       (clk),
        .reset     (reset),
        .memAdrs   (memAdrs),
        .memDataWD (memDataWD),
        .dmem_SEL  (dmem_SEL),
        .dmem_WE   (dmem_WE),
        .dmem_RE   (dmem_RE),
        .flush_M   (flush_M),
        .memDataRD (memDataRD),
        .stall_req (stall_req),
        .misalign  (misalign),
        .bus_err   (bus_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    typedef struct packed {
        logic        we;
        logic        re;
        logic [2:0]  sel;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        logic        fault;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        memAdrs   = '0;
        memDataWD = '0;
        dmem_SEL  = '0;
        dmem_WE   = 1'b0;
        dmem_RE   = 1'b0;
        flush_M   = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic present(input logic we, input logic re, input logic [2:0] sel,
                           input logic [31:0] addr, input logic [31:0] wd);
        dmem_WE   = we;
        dmem_RE   = re;
        dmem_SEL  = sel;
        memAdrs   = addr;
        memDataWD = wd;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string nm;
        nm = $sformatf("v%0d", idx);
        @(posedge clk); #1;
        present(v.we, v.re, v.sel, v.addr, v.wd);
        mem_rdata = v.rdata;
        mem_ready = 1'b0;
        @(negedge clk);
        chk({nm, " misalign"}, 32'(misalign), 32'(v.fault));
        chk({nm, " stall0"}, 32'(stall_req), 32'(!v.fault));
        chk({nm, " req0"}, 32'(mem_req), 32'd0);
        if (v.fault) begin
            chk({nm, " rd_fault"}, memDataRD, 32'h0);
            @(posedge clk); #1;
            clear_inputs();
            @(negedge clk);
            chk({nm, " req_after_fault"}, 32'(mem_req), 32'd0);
        end else begin
            @(posedge clk); #1;
            mem_ready = 1'b1;
            @(negedge clk);
            chk({nm, " req1"}, 32'(mem_req), 32'd1);
            chk({nm, " stall1"}, 32'(stall_req), 32'd1);
            chk({nm, " addr"}, 32'(mem_addr), 32'(v.addr[31:2]));
            chk({nm, " we"}, 32'(mem_we), 32'(v.we));
            if (v.we) begin
                chk({nm, " wstrb"}, 32'(mem_wstrb), 32'(v.strb));
                chk({nm, " wdata"}, mem_wdata, v.wdata);
            end
            @(posedge clk); #1;
            mem_ready = 1'b0;
            @(negedge clk);
            chk({nm, " stall_done"}, 32'(stall_req), 32'd0);
            chk({nm, " req_done"}, 32'(mem_req), 32'd0);
            chk({nm, " rd"}, memDataRD, v.rd);
            chk({nm, " err"}, 32'(bus_err), 32'd0);
            @(posedge clk); #1;
            clear_inputs();
        end
    endtask

    initial begin
        int busy_cycles;

        vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 4'hF, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h203, 32'h0000005A, 32'h0, 1'b0, 4'h8, 32'h5A5A5A5A, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 3'b000, 32'h203, 32'h0, 32'h80123456, 1'b0, 4'h0, 32'h0, 32'hFFFFFF80};
        vecs[3]  = '{1'b0, 1'b1, 3'b100, 32'h203, 32'h0, 32'h80123456, 1'b0, 4'h0, 32'h0, 32'h00000080};
        vecs[4]  = '{1'b0, 1'b1, 3'b001, 32'h102, 32'h0, 32'h80011234, 1'b0, 4'h0, 32'h0, 32'hFFFF8001};
        vecs[5]  = '{1'b0, 1'b1, 3'b101, 32'h100, 32'h0, 32'h8001F234, 1'b0, 4'h0, 32'h0, 32'h0000F234};
        vecs[6]  = '{1'b0, 1'b1, 3'b010, 32'h104, 32'h0, 32'h12345678, 1'b0, 4'h0, 32'h0, 32'h12345678};
        vecs[7]  = '{1'b0, 1'b1, 3'b001, 32'h101, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0};
        vecs[8]  = '{1'b0, 1'b1, 3'b010, 32'h102, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0};
        vecs[9]  = '{1'b0, 1'b1, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 3'b100, 32'h100, 32'h55, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0};
        vecs[11] = '{1'b1, 1'b0, 3'b001, 32'h106, 32'hABCD1234, 32'h0, 1'b0, 4'hC, 32'h12341234, 32'h0};
        vecs[12] = '{1'b0, 1'b1, 3'b000, 32'h001, 32'h0, 32'h00007F00, 1'b0, 4'h0, 32'h0, 32'h0000007F};
        vecs[13] = '{1'b1, 1'b1, 3'b010, 32'h108, 32'hCAFEF00D, 32'h0, 1'b0, 4'hF, 32'hCAFEF00D, 32'h0};
        vecs[14] = '{1'b0, 1'b1, 3'b000, 32'h002, 32'h0, 32'h00AB0000, 1'b0, 4'h0, 32'h0, 32'hFFFFFFAB};

        clear_inputs();
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst mem_req", 32'(mem_req), 32'd0);
        chk("rst stall", 32'(stall_req), 32'd0);
        chk("rst rd", memDataRD, 32'h0);
        chk("rst bus_err", 32'(bus_err), 32'd0);
        chk("rst wstrb", 32'(mem_wstrb), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

        // Timeout: mem_ready never arrives.
        @(posedge clk); #1;
        present(1'b0, 1'b1, 3'b010, 32'h200, 32'h0);
        @(negedge clk);
        chk("to stall0", 32'(stall_req), 32'd1);
        busy_cycles = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!mem_req) break;
            busy_cycles++;
        end
        chk("to busy_cycles", 32'(busy_cycles), 32'd64);
        chk("to bus_err", 32'(bus_err), 32'd1);
        chk("to rd", memDataRD, 32'h0);
        chk("to stall_done", 32'(stall_req), 32'd0);
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        chk("to err_pulse", 32'(bus_err), 32'd0);
        chk("to idle_req", 32'(mem_req), 32'd0);

        // Reset during the 5th BUSY cycle.
        @(posedge clk); #1;
        present(1'b0, 1'b1, 3'b010, 32'h300, 32'h0);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            if (k == 5) begin
                reset = 1'b1;
                clear_inputs();
            end
            @(negedge clk);
            if (k < 5) chk($sformatf("rstbusy req%0d", k), 32'(mem_req), 32'd1);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rstbusy req", 32'(mem_req), 32'd0);
        chk("rstbusy stall", 32'(stall_req), 32'd0);

        // LW with three wait cycles after reset.
        @(posedge clk); #1;
        present(1'b0, 1'b1, 3'b010, 32'h304, 32'h0);
        mem_rdata = 32'h0BADCAFE;
        @(negedge clk);
        chk("wait stall0", 32'(stall_req), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("wait req%0d", k), 32'(mem_req), 32'd1);
        end
        @(posedge clk); #1;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("wait addr", 32'(mem_addr), 32'h0C1);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("wait stall_done", 32'(stall_req), 32'd0);
        chk("wait rd", memDataRD, 32'h0BADCAFE);
        chk("wait err", 32'(bus_err), 32'd0);
        @(posedge clk); #1;
        clear_inputs();

        // Flushed load in IDLE issues nothing.
        @(posedge clk); #1;
        present(1'b0, 1'b1, 3'b010, 32'h400, 32'h0);
        flush_M = 1'b1;
        @(negedge clk);
        chk("flush stall", 32'(stall_req), 32'd0);
        chk("flush misalign", 32'(misalign), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("flush req", 32'(mem_req), 32'd0);
        chk("flush rd_kept", memDataRD, 32'h0BADCAFE);
        clear_inputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
